// File: rtl/adc_lvds_serializer.sv
// ADC emulator: accepts parallel samples and streams them MSB-first with frame and bit clock.
// Optional ADC_SER_RAMP_EN substitutes an incrementing ramp instead of IDLE_WORD on underrun.
module adc_lvds_serializer #(
    parameter int              WIDTH     = 12,
    parameter logic [WIDTH-1:0] IDLE_WORD = 12'hA5A,
    parameter int              CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DVALID,
    output logic             DREADY,
    output logic             adc_fastclk,
    output logic             adc_frame,
    output logic             adcdata_p,
    output logic             BUSY,
    output logic [CNT_W-1:0] SENT_COUNT,
    output logic [CNT_W-1:0] UNDERRUN_COUNT
);

    localparam int               BC_W      = $clog2(WIDTH);
    localparam logic [BC_W-1:0]  LAST_BIT  = BC_W'(WIDTH - 1);
    localparam logic [BC_W-1:0]  HALF_BITS = BC_W'(WIDTH / 2);
    localparam logic [BC_W-1:0]  BC_ONE    = {{(BC_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_phase;
    logic [BC_W-1:0]  r_bitcnt;
    logic [WIDTH-1:0] r_shreg;
    logic             r_data;
    logic             r_frame;
    logic             r_fastclk;
    logic [CNT_W-1:0] r_sent;
    logic [CNT_W-1:0] r_underrun;
    logic             w_word_end;
    logic             w_load;
    logic [WIDTH-1:0] w_sub_word;

    assign w_word_end = (r_state == S_RUN) && r_phase && (r_bitcnt == LAST_BIT);
    // No sample may be accepted while reset is clearing the pipeline.
    assign w_load     = !RESET && ENABLE && ((r_state == S_IDLE) || w_word_end);

    assign DREADY         = w_load;
    assign BUSY           = (r_state == S_RUN);
    assign adcdata_p      = r_data;
    assign adc_frame      = r_frame;
    assign adc_fastclk    = r_fastclk;
    assign SENT_COUNT     = r_sent;
    assign UNDERRUN_COUNT = r_underrun;

`ifdef ADC_SER_RAMP_EN
    logic [WIDTH-1:0] r_ramp;
    localparam logic [WIDTH-1:0] RAMP_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Ramp advances after every substituted word.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ramp <= {WIDTH{1'b0}};
        end else if (w_load && !DVALID) begin
            r_ramp <= r_ramp + RAMP_ONE;
        end else begin
            r_ramp <= r_ramp;
        end
    end

    assign w_sub_word = r_ramp;
`else
    assign w_sub_word = IDLE_WORD;
`endif

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: a running word always completes before returning to idle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_load) begin
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_word_end && !ENABLE) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_RUN;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Shift register, bit phase and bit counter.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_phase  <= 1'b0;
            r_bitcnt <= {BC_W{1'b0}};
            r_shreg  <= {WIDTH{1'b0}};
        end else if (w_load) begin
            r_phase  <= 1'b0;
            r_bitcnt <= {BC_W{1'b0}};
            r_shreg  <= DVALID ? DIN : w_sub_word;
        end else if (r_state == S_RUN) begin
            r_phase <= ~r_phase;
            if (r_phase) begin
                r_bitcnt <= w_word_end ? {BC_W{1'b0}} : (r_bitcnt + BC_ONE);
                r_shreg  <= {r_shreg[WIDTH-2:0], 1'b0};
            end else begin
                r_bitcnt <= r_bitcnt;
                r_shreg  <= r_shreg;
            end
        end else begin
            r_phase  <= r_phase;
            r_bitcnt <= r_bitcnt;
            r_shreg  <= r_shreg;
        end
    end

    // Serial outputs lag the shift state by one cycle so each bit lasts two full cycles.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_data    <= 1'b0;
            r_frame   <= 1'b0;
            r_fastclk <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_data    <= r_shreg[WIDTH-1];
            r_frame   <= (r_bitcnt < HALF_BITS);
            r_fastclk <= r_phase;
        end else begin
            r_data    <= 1'b0;
            r_frame   <= 1'b0;
            r_fastclk <= 1'b0;
        end
    end

    // Saturating word and underrun counters; a start-up idle word is not an underrun.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sent     <= {CNT_W{1'b0}};
            r_underrun <= {CNT_W{1'b0}};
        end else if (w_load) begin
            r_sent <= (&r_sent) ? r_sent : (r_sent + CNT_ONE);
            if ((r_state == S_RUN) && !DVALID && !(&r_underrun)) begin
                r_underrun <= r_underrun + CNT_ONE;
            end else begin
                r_underrun <= r_underrun;
            end
        end else begin
            r_sent     <= r_sent;
            r_underrun <= r_underrun;
        end
    end

endmodule

// File: tb/tb_adc_lvds_serializer.sv
// Directed bench for adc_lvds_serializer: bit stream, framing, underrun, stop, reset and loopback.
module tb_adc_lvds_serializer;

    logic        CLK;
    logic        RESET;
    logic        ENABLE;
    logic [11:0] DIN;
    logic        DVALID;
    logic        DREADY;
    logic        adc_fastclk;
    logic        adc_frame;
    logic        adcdata_p;
    logic        BUSY;
    logic [15:0] SENT_COUNT;
    logic [15:0] UNDERRUN_COUNT;

    int total = 0;
    int bad   = 0;

`ifdef ADC_SER_RAMP_EN
    localparam logic [11:0] SUB0 = 12'h000;
    localparam logic [11:0] SUB1 = 12'h001;
`else
    localparam logic [11:0] SUB0 = 12'hA5A;
    localparam logic [11:0] SUB1 = 12'hA5A;
`endif

    adc_lvds_serializer dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .ENABLE         (ENABLE),
        .DIN            (DIN),
        .DVALID         (DVALID),
        .DREADY         (DREADY),
        .adc_fastclk    (adc_fastclk),
        .adc_frame      (adc_frame),
        .adcdata_p      (adcdata_p),
        .BUSY           (BUSY),
        .SENT_COUNT     (SENT_COUNT),
        .UNDERRUN_COUNT (UNDERRUN_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Receiver model: samples data on each bit-clock rise, frame rise marks word start.
    logic        rx_on = 1'b0;
    logic        rx_pf = 1'b0;
    int          rx_n  = 0;
    logic [11:0] rx_sh = 12'h000;
    logic [11:0] rx_q[$];

    always @(posedge adc_fastclk) begin
        if (rx_on) begin
            if (adc_frame && !rx_pf) begin
                rx_n  = 1;
                rx_sh = {11'b0, adcdata_p};
            end else begin
                rx_n  = rx_n + 1;
                rx_sh = {rx_sh[10:0], adcdata_p};
            end
            if (rx_n == 12) rx_q.push_back(rx_sh);
            rx_pf = adc_frame;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Follows one 24-cycle word starting at the edge after its load.
    task automatic check_word(input logic [11:0] w, input int drop_at);
        for (int c = 0; c < 24; c++) begin
            tick();
            chk($sformatf("data w=%h c=%0d", w, c), {31'b0, adcdata_p}, {31'b0, w[11 - c/2]});
            chk($sformatf("frame w=%h c=%0d", w, c), {31'b0, adc_frame}, (c < 12) ? 32'd1 : 32'd0);
            chk($sformatf("fclk w=%h c=%0d", w, c), {31'b0, adc_fastclk}, 32'(c % 2));
            chk($sformatf("dready w=%h c=%0d", w, c), {31'b0, DREADY},
                ((c == 22) && ENABLE) ? 32'd1 : 32'd0);
            if (c == drop_at) ENABLE = 1'b0;
        end
    endtask

    logic [11:0] samples [8];
    int          waited;

    initial begin
        samples = '{12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF, 12'h0F0, 12'hF0F, 12'h800};
        RESET = 1'b1; ENABLE = 1'b0; DVALID = 1'b0; DIN = 12'h000;
        repeat (3) tick();
        RESET = 1'b0;
        tick();
        chk("rst data", {31'b0, adcdata_p}, 32'd0);
        chk("rst frame", {31'b0, adc_frame}, 32'd0);
        chk("rst fclk", {31'b0, adc_fastclk}, 32'd0);
        chk("rst busy", {31'b0, BUSY}, 32'd0);
        chk("rst sent", {16'b0, SENT_COUNT}, 32'd0);
        chk("rst under", {16'b0, UNDERRUN_COUNT}, 32'd0);
        chk("rst dready", {31'b0, DREADY}, 32'd0);

        // First word from idle, then back-to-back words.
        ENABLE = 1'b1; DVALID = 1'b1; DIN = 12'hC35;
        #1;
        chk("dready at enable", {31'b0, DREADY}, 32'd1);
        tick();
        chk("busy after load", {31'b0, BUSY}, 32'd1);
        chk("sent after load", {16'b0, SENT_COUNT}, 32'd1);
        chk("dready after load", {31'b0, DREADY}, 32'd0);
        DIN = 12'h001;
        check_word(12'hC35, -1);
        chk("sent 2", {16'b0, SENT_COUNT}, 32'd2);
        DIN = 12'hFFF;
        check_word(12'h001, -1);
        chk("sent 3", {16'b0, SENT_COUNT}, 32'd3);
        chk("under 0", {16'b0, UNDERRUN_COUNT}, 32'd0);

        // Underruns substitute the idle/ramp word.
        DVALID = 1'b0;
        check_word(12'hFFF, -1);
        chk("sent 4", {16'b0, SENT_COUNT}, 32'd4);
        chk("under 1", {16'b0, UNDERRUN_COUNT}, 32'd1);
        DVALID = 1'b1; DIN = 12'h3C3;
        check_word(SUB0, -1);
        chk("sent 5", {16'b0, SENT_COUNT}, 32'd5);
        chk("under 1b", {16'b0, UNDERRUN_COUNT}, 32'd1);
        DVALID = 1'b0;
        check_word(12'h3C3, -1);
        chk("sent 6", {16'b0, SENT_COUNT}, 32'd6);
        chk("under 2", {16'b0, UNDERRUN_COUNT}, 32'd2);

        // ENABLE dropped at cycle 5: word completes, then idle.
        check_word(SUB1, 5);
        chk("busy after stop", {31'b0, BUSY}, 32'd0);
        chk("sent after stop", {16'b0, SENT_COUNT}, 32'd6);
        chk("under after stop", {16'b0, UNDERRUN_COUNT}, 32'd2);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle data", {31'b0, adcdata_p}, 32'd0);
            chk("idle frame", {31'b0, adc_frame}, 32'd0);
            chk("idle fclk", {31'b0, adc_fastclk}, 32'd0);
            chk("idle dready", {31'b0, DREADY}, 32'd0);
            chk("idle busy", {31'b0, BUSY}, 32'd0);
        end

        // Reset in the middle of a word.
        ENABLE = 1'b1; DVALID = 1'b1; DIN = 12'h5A5;
        #1;
        chk("dready restart", {31'b0, DREADY}, 32'd1);
        tick();
        DVALID = 1'b0;
        repeat (10) tick();
        chk("mid fclk", {31'b0, adc_fastclk}, 32'd1);
        chk("mid data", {31'b0, adcdata_p}, 32'd1);
        chk("mid sent", {16'b0, SENT_COUNT}, 32'd7);
        RESET = 1'b1;
        tick();
        chk("abort data", {31'b0, adcdata_p}, 32'd0);
        chk("abort frame", {31'b0, adc_frame}, 32'd0);
        chk("abort fclk", {31'b0, adc_fastclk}, 32'd0);
        chk("abort busy", {31'b0, BUSY}, 32'd0);
        chk("abort sent", {16'b0, SENT_COUNT}, 32'd0);
        chk("abort under", {16'b0, UNDERRUN_COUNT}, 32'd0);
        RESET = 1'b0; ENABLE = 1'b0; DVALID = 1'b0;
        tick();

        // Loopback through the receiver model.
        rx_on = 1'b1;
        ENABLE = 1'b1;
        for (int k = 0; k < 8; k++) begin
            DIN = samples[k]; DVALID = 1'b1;
            #1;
            waited = 0;
            while (!DREADY && waited < 40) begin
                tick();
                waited++;
            end
            chk($sformatf("lb ready k=%0d", k), {31'b0, DREADY}, 32'd1);
            tick();
        end
        ENABLE = 1'b0; DVALID = 1'b0;
        repeat (30) tick();
        rx_on = 1'b0;
        chk("lb count", 32'(rx_q.size()), 32'd8);
        chk("lb sent", {16'b0, SENT_COUNT}, 32'd8);
        chk("lb under", {16'b0, UNDERRUN_COUNT}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            if (k < rx_q.size()) chk($sformatf("lb word %0d", k), {20'b0, rx_q[k]}, {20'b0, samples[k]});
            else chk($sformatf("lb missing %0d", k), 32'd0, 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_lvds_serializer.md
Name: adc_lvds_serializer

Overview:
- Transmit-side counterpart of the per-channel LVDS receiver.
- Takes parallel ADC samples through a valid/ready handshake and serializes them MSB-first onto adcdata_p, together with a frame signal (adc_frame) and a bit clock (adc_fastclk).
- Drives the channel receive path in loopback and board self-test, and stands in for the physical ADC in simulation.

Parameters:
- WIDTH, 12, sample width in bits; must be even and at least 4.
- IDLE_WORD, 12'hA5A, word sent when no sample is available at a word boundary; width is WIDTH.
- CNT_W, 16, width of the sent and underrun counters.

Ports:
- CLK  input  1  system clock. 2 CLK cycles make 1 serial bit period.
- RESET  input  1  reset, synchronous and active-high.
- ENABLE  input  1  starts and stops serialization; sampled only at load events.
- DIN  input  WIDTH  parallel sample.
- DVALID  input  1  DIN is valid.
- DREADY  output  1  serializer accepts DIN this cycle.
- adc_fastclk  output  1  bit clock; rises at the centre of each bit.
- adc_frame  output  1  high for the first WIDTH/2 bits of each word, low for the rest.
- adcdata_p  output  1  serial data, MSB first.
- BUSY  output  1  in the RUN state.
- SENT_COUNT  output  CNT_W  number of words transmitted, including idle words.
- UNDERRUN_COUNT  output  CNT_W  number of idle words substituted while running.

Behaviour:
- Clock and reset: one clock domain, CLK. RESET is synchronous and active-high. On reset, all outputs and counters go to 0, the state goes to IDLE and the shift register clears.
- State machine:
  - IDLE: adcdata_p, adc_frame and adc_fastclk are held 0.
  - RUN: words stream back to back.
- Counters in RUN:
  - phase: 1 bit, toggles every cycle.
  - bitcnt: 0..WIDTH-1, increments when phase=1.
- Last cycle of a word: bitcnt=WIDTH-1 and phase=1.
- Load event L:
  - In IDLE: when ENABLE=1.
  - In RUN: on the last cycle of a word when ENABLE=1.
- DREADY = L (combinational from state, counters and ENABLE). It does not depend on DVALID.
- At L:
  - shreg <= DVALID ? DIN : IDLE_WORD.
  - state <= RUN.
  - phase and bitcnt <= 0.
  - A sample is accepted only when DVALID & DREADY.
- In RUN, at the last cycle of a word with ENABLE=0:
  - state <= IDLE.
  - The current word always completes; it is never truncated.
- Registered outputs in RUN:
  - adcdata_p = shreg[WIDTH-1]. shreg shifts left (zero fill) when phase=1.
  - adc_fastclk = phase.
  - adc_frame = (bitcnt < WIDTH/2).
- Latency: a sample accepted at edge N drives its MSB on adcdata_p from cycle N+1 for 2 cycles. A word occupies 2*WIDTH cycles. There are no gap cycles between consecutive words.
- Counters:
  - SENT_COUNT increments at each L.
  - UNDERRUN_COUNT increments at an L in the RUN state when DVALID=0. An idle word sent as the very first word from IDLE is not counted.
  - Both saturate at all-ones; they do not wrap.
- DVALID asserted outside L is ignored. DIN is not required to stay stable after acceptance.
- ENABLE toggling mid-word has no effect until the last cycle of the word.
- RESET mid-word aborts immediately. All outputs are 0 on the following cycle.
- BUSY = (state==RUN).

Optional Feature:
- Macro: ADC_SER_RAMP_EN.
- When defined:
  - An internal WIDTH-bit ramp register, reset to 0, replaces IDLE_WORD as the substitute word.
  - The ramp increments (wrapping) after each substitution.
  - UNDERRUN_COUNT still counts substitutions.
- When undefined: no ramp register is built, and IDLE_WORD is substituted.

Test Plan:
- Reset, then ENABLE=1 with DVALID=1 and DIN=12'hC35:
  - DREADY is high in the cycle ENABLE rises.
  - adcdata_p shows 1,1,0,0,0,0,1,1,0,1,0,1, each bit held 2 cycles.
  - adc_frame is high for the first 12 cycles, then low for 12.
  - SENT_COUNT=1.
- Continuous DVALID with DIN=12'h001 then 12'hFFF:
  - The words are back to back; the second MSB starts exactly 24 cycles after the first.
  - DREADY pulses once every 24 cycles.
- DVALID=0 at the second load event:
  - 12'hA5A is transmitted.
  - UNDERRUN_COUNT=1, SENT_COUNT=2.
  - With ADC_SER_RAMP_EN defined, 12'h000 is sent first, then 12'h001 at the next underrun.
- ENABLE dropped at cycle 5 of a word:
  - The word completes all 24 cycles.
  - Then IDLE: outputs 0, BUSY=0, and no further DREADY.
- RESET asserted at cycle 10 of a word:
  - On the next cycle, adcdata_p, adc_frame, adc_fastclk, BUSY and both counters are 0.
- Loopback: connect to the channel LVDS receiver and send a sequence of 8 samples. CBDATA must match the sequence in order, with no drops.
